// File: rtl/fpg8_pkg.sv
// Shared definitions for the FPG8 control sequencer: opcodes, FSM state
// encodings and opcode/state classification helpers.
package fpg8_pkg;

    localparam logic [3:0] OP_NOP   = 4'b0000;
    localparam logic [3:0] OP_LOAD  = 4'b0001;
    localparam logic [3:0] OP_STORE = 4'b0010;
    localparam logic [3:0] OP_ADD   = 4'b0011;
    localparam logic [3:0] OP_SUB   = 4'b0100;
    localparam logic [3:0] OP_AND   = 4'b0101;
    localparam logic [3:0] OP_OR    = 4'b0110;
    localparam logic [3:0] OP_NOT   = 4'b0111;
    localparam logic [3:0] OP_CMP   = 4'b1000;
    localparam logic [3:0] OP_BR    = 4'b1001;
    localparam logic [3:0] OP_BZ    = 4'b1010;
    localparam logic [3:0] OP_BN    = 4'b1011;
    localparam logic [3:0] OP_HALT  = 4'b1111;

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_F_ADDR   = 4'd1,
        S_F_MEM    = 4'd2,
        S_DECODE   = 4'd3,
        S_OP_ADDR  = 4'd4,
        S_OP_READ  = 4'd5,
        S_LD_EXEC  = 4'd6,
        S_OP_WRITE = 4'd7,
        S_BR_READ  = 4'd8,
        S_ALU      = 4'd9,
        S_FAULT    = 4'd10
    } state_t;

    // Arithmetic/logic operations that write the accumulator (CMP excluded).
    function automatic logic is_alu(input logic [3:0] op);
        return (op >= OP_ADD) && (op <= OP_NOT);
    endfunction

    function automatic logic is_branch(input logic [3:0] op);
        return (op == OP_BR) || (op == OP_BZ) || (op == OP_BN);
    endfunction

    // Instructions with a data-memory operand.
    function automatic logic is_mem(input logic [3:0] op);
        return (op == OP_LOAD) || (op == OP_STORE);
    endfunction

    // States that wait on the memory handshake and are covered by the watchdog.
    function automatic logic is_mem_state(input state_t s);
        return (s == S_F_MEM) || (s == S_OP_READ) || (s == S_OP_WRITE) || (s == S_BR_READ);
    endfunction

    function automatic logic branch_taken(input logic [3:0] op, input logic z, input logic n);
        return (op == OP_BR) || ((op == OP_BZ) && z) || ((op == OP_BN) && n);
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Watchdog counter for memory wait states; flags the cycle on which the
// MEM_TIMEOUT-th consecutive wait cycle occurs.
module mem_wait_timer #(
    parameter int MEM_TIMEOUT = 15,
    parameter int TMR_W       = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic count,
    output logic timeout
);

    localparam logic [TMR_W-1:0] CNT_MAX = '1;

    logic [TMR_W-1:0] cnt_q;
    logic [TMR_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (count && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // cnt_q holds the waits already seen, so this is the MEM_TIMEOUT-th wait.
    generate
        if (MEM_TIMEOUT > 0) begin : g_watchdog
            localparam logic [TMR_W-1:0] LAST_WAIT = TMR_W'(MEM_TIMEOUT - 1);
            assign timeout = count && (cnt_q == LAST_WAIT);
        end else begin : g_no_watchdog
            assign timeout = 1'b0;
        end
    endgenerate

endmodule

// File: rtl/control_sequencer.sv
// Fetch/decode/execute sequencer for the FPG8 datapath: walks the instruction
// cycle and decodes every bus/register strobe from the current state.
module control_sequencer
    import fpg8_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15,
    parameter int TMR_W       = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       run,
    input  logic       mem_ready,
    input  logic [3:0] IR_opcode,
    input  logic       IR_S,
    input  logic       PSW_Z,
    input  logic       PSW_N,
    output logic       pc_enable,
    output logic       pc_latch,
    output logic       pc_inc,
    output logic       mar_latch,
    output logic       ir_latch,
    output logic       mem_read,
    output logic       mem_write,
    output logic       mdr_latch,
    output logic       mdr_enable,
    output logic       acc_latch,
    output logic       acc_enable,
    output logic       alu_enable,
    output logic [3:0] alu_op,
    output logic       psw_latch,
    output logic       psw_enable,
    output logic       halted,
    output logic       fault
);

    state_t state_q;
    state_t state_d;
    logic   taken_q;
    logic   taken_d;
    logic   in_mem;
    logic   timeout;

    assign in_mem = is_mem_state(state_q);

    // Memory states never chain directly, so holding the counter clear outside
    // them guarantees it starts from zero on every entry.
    mem_wait_timer #(
        .MEM_TIMEOUT (MEM_TIMEOUT),
        .TMR_W       (TMR_W)
    ) u_mem_wait_timer (
        .clk     (clk),
        .reset   (reset),
        .clear   (!in_mem),
        .count   (in_mem && !mem_ready),
        .timeout (timeout)
    );

    always_comb begin
        state_d = state_q;
        taken_d = taken_q;
        case (state_q)
            S_IDLE:     if (run) state_d = S_F_ADDR;
            S_F_ADDR:   state_d = S_F_MEM;
            S_F_MEM: begin
                if (mem_ready)    state_d = S_DECODE;
                else if (timeout) state_d = S_FAULT;
            end
            S_DECODE: begin
                // Flags are captured here only; later PSW changes cannot flip the decision.
                taken_d = branch_taken(IR_opcode, PSW_Z, PSW_N);
                if (IR_opcode == OP_HALT)
                    state_d = S_IDLE;
                else if (is_alu(IR_opcode) || (IR_opcode == OP_CMP))
                    state_d = S_ALU;
                else if (is_mem(IR_opcode) || is_branch(IR_opcode))
                    state_d = S_OP_ADDR;
                else
                    state_d = S_F_ADDR;
            end
            S_OP_ADDR: begin
                if (IR_opcode == OP_LOAD)       state_d = S_OP_READ;
                else if (IR_opcode == OP_STORE) state_d = S_OP_WRITE;
                else if (is_branch(IR_opcode))  state_d = S_BR_READ;
                else                            state_d = S_F_ADDR;
            end
            S_OP_READ: begin
                if (mem_ready)    state_d = S_LD_EXEC;
                else if (timeout) state_d = S_FAULT;
            end
            S_LD_EXEC:  state_d = S_F_ADDR;
            S_OP_WRITE, S_BR_READ: begin
                if (mem_ready)    state_d = S_F_ADDR;
                else if (timeout) state_d = S_FAULT;
            end
            S_ALU:      state_d = S_F_ADDR;
            S_FAULT:    state_d = S_FAULT;
            default:    state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            taken_q <= 1'b0;
        end else begin
            state_q <= state_d;
            taken_q <= taken_d;
        end
    end

    always_comb begin
        pc_enable  = 1'b0;
        pc_latch   = 1'b0;
        pc_inc     = 1'b0;
        mar_latch  = 1'b0;
        ir_latch   = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mdr_latch  = 1'b0;
        mdr_enable = 1'b0;
        acc_latch  = 1'b0;
        acc_enable = 1'b0;
        alu_enable = 1'b0;
        alu_op     = 4'b0000;
        psw_latch  = 1'b0;
        psw_enable = 1'b0;
        halted     = 1'b0;
        fault      = 1'b0;
        case (state_q)
            S_IDLE:  halted = 1'b1;
            S_F_ADDR, S_OP_ADDR: begin
                pc_enable = 1'b1;
                mar_latch = 1'b1;
            end
            S_F_MEM: begin
                mem_read = 1'b1;
                ir_latch = mem_ready;
                pc_inc   = mem_ready;
            end
            S_OP_READ: begin
                mem_read  = 1'b1;
                mdr_latch = mem_ready;
                pc_inc    = mem_ready;
            end
            S_LD_EXEC: begin
                mdr_enable = 1'b1;
                acc_latch  = 1'b1;
                psw_latch  = IR_S;
            end
            S_OP_WRITE: begin
                acc_enable = 1'b1;
                mem_write  = 1'b1;
                pc_inc     = mem_ready;
            end
            S_BR_READ: begin
                mem_read = 1'b1;
                pc_latch = mem_ready && taken_q;
                pc_inc   = mem_ready && !taken_q;
            end
            S_ALU: begin
                alu_enable = 1'b1;
                alu_op     = IR_opcode;
                acc_latch  = (IR_opcode != OP_CMP);
                psw_latch  = IR_S || (IR_opcode == OP_CMP);
            end
            S_FAULT: begin
                halted = 1'b1;
                fault  = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
Fetch/decode/execute state machine for the FPG8 datapath. Consumes the IR opcode, the IR S bit and the PSW Z/N flags. Produces every register latch/enable strobe on the shared 16-bit bus, including the PSW latch and enable. Handles variable memory wait states with a ready handshake and a watchdog timeout.

Parameters:
MEM_TIMEOUT, 15, max cycles a memory state waits for mem_ready before faulting; 0 disables the watchdog
TMR_W, 4, width of wait-cycle counter; must satisfy 2^TMR_W > MEM_TIMEOUT

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
run  input  1  start/resume request; honoured only in IDLE
mem_ready  input  1  memory has completed the current read/write this cycle
IR_opcode  input  4  IR[15:12], valid from DECODE onward
IR_S  input  1  set-flags bit of the current instruction
PSW_Z  input  1  PSW zero flag
PSW_N  input  1  PSW negative flag
pc_enable  output  1  PC drives bus
pc_latch  output  1  PC loads from bus
pc_inc  output  1  PC increments
mar_latch  output  1  MAR loads from bus
ir_latch  output  1  IR loads from memory data
mem_read  output  1  memory read request
mem_write  output  1  memory write request
mdr_latch  output  1  MDR loads from memory data
mdr_enable  output  1  MDR drives bus
acc_latch  output  1  ACC loads from bus
acc_enable  output  1  ACC drives bus
alu_enable  output  1  ALU result drives bus
alu_op  output  4  ALU function; equals IR_opcode in ALU state, else 0
psw_latch  output  1  PSW captures flags
psw_enable  output  1  PSW drives bus; always 0 in this revision
halted  output  1  in IDLE or FAULT
fault  output  1  memory timeout occurred; sticky until reset

Behaviour:
- Reset low: state=IDLE, timer=0, taken_q=0. All strobes 0. alu_op=0. halted=1. fault=0. Reset takes effect immediately, including mid-instruction.
- Strobes are decoded combinationally from state, mem_ready, IR_S, IR_opcode and taken_q. At most one bus driver is active per cycle.
- Opcode classes:
  - 0000 NOP; 0001 LOAD; 0010 STORE.
  - 0011-0111 ALU (ADD, SUB, AND, OR, NOT); 1000 CMP.
  - 1001 BR; 1010 BZ; 1011 BN; 1111 HALT.
  - 1100-1110 are undefined and execute as NOP.
- States and transitions:
  - IDLE: halted=1. If run=1, go to F_ADDR.
  - F_ADDR: pc_enable, mar_latch. Go to F_MEM.
  - F_MEM: mem_read. When mem_ready=1: ir_latch and pc_inc, then go to DECODE. Otherwise stay.
  - DECODE: no strobes. Register taken_q = BR | (BZ & PSW_Z) | (BN & PSW_N). Dispatch:
    - NOP/undefined to F_ADDR; ALU/CMP to ALU; HALT to IDLE.
    - LOAD, STORE and branches to OP_ADDR.
  - OP_ADDR: pc_enable, mar_latch. LOAD goes to OP_READ; STORE goes to OP_WRITE; branches go to BR_READ.
  - OP_READ: mem_read. When mem_ready=1: mdr_latch and pc_inc, then go to LD_EXEC.
  - LD_EXEC: mdr_enable, acc_latch; psw_latch = IR_S. Go to F_ADDR.
  - OP_WRITE: acc_enable, mem_write. When mem_ready=1: pc_inc, then go to F_ADDR.
  - BR_READ: mem_read. When mem_ready=1: if taken_q, pc_latch (target from memory data); else pc_inc. Then go to F_ADDR.
  - ALU: alu_enable, alu_op=IR_opcode. acc_latch unless CMP. psw_latch = IR_S | CMP. Go to F_ADDR.
  - FAULT: halted=1, fault=1, all strobes 0. Exited only by reset.
- Flags are sampled once, in DECODE. A PSW update in the same cycle does not change the branch decision.
- Watchdog:
  - The timer clears on entry to any memory state (F_MEM, OP_READ, OP_WRITE, BR_READ).
  - It increments each cycle mem_ready=0 while in that state.
  - If MEM_TIMEOUT>0 and the timer reaches MEM_TIMEOUT with mem_ready still 0, go to FAULT.
  - mem_ready=1 on the timeout cycle wins; the transfer completes normally.
- run is ignored outside IDLE, including in FAULT.
- Latency with zero wait states: NOP 3 cycles, ALU/CMP 4, STORE 5, branch 5, LOAD 6. Each wait cycle adds 1.

Decomposition:
- fpg8_pkg holds:
  - opcode localparams;
  - state encodings (4-bit);
  - functions is_alu(op), is_branch(op), is_mem(op).
- One sub-module, mem_wait_timer (clear, count, MEM_TIMEOUT, timeout output), holds the watchdog counter.

Test Plan:
- Reset low mid-F_MEM -> next sample: all strobes 0, halted=1, state IDLE. Release reset with run=0 -> stays IDLE.
- run=1, opcode 0011, IR_S=1, mem_ready tied 1 -> 4 cycles: pc_enable+mar_latch; then mem_read+ir_latch+pc_inc; then idle cycle; then alu_enable, alu_op=0011, acc_latch, psw_latch. Next state F_ADDR.
- Opcode 1010 with PSW_Z=1 at DECODE, PSW_Z forced to 0 next cycle -> BR_READ asserts pc_latch (taken_q held), pc_inc=0. Repeat with PSW_Z=0 -> pc_inc=1, pc_latch=0.
- LOAD with mem_ready low 3 cycles in OP_READ -> mem_read held 4 cycles. mdr_latch only on the ready cycle, then LD_EXEC: mdr_enable+acc_latch. psw_latch=0 when IR_S=0.
- STORE with mem_ready stuck 0, MEM_TIMEOUT=15 -> FAULT after 15 wait cycles. fault=halted=1, mem_write drops. run=1 ignored; only reset clears fault.
- Opcode 1111 -> DECODE to IDLE, halted=1. run pulse -> fetch resumes at F_ADDR. Opcode 1100 -> behaves as NOP, 3 cycles.
